spike_event_serializer: RTL and testbench

Downstream neighbour of the convolution layer's pooled output. Buffers pooled output vectors in a local FIFO. Each vector carries a pooled coordinate and an OUT_CHANNELS-wide spike mask; the block serializes it into one address event per set channel, presented on a valid/ready stream. It also forwards timestep-boundary tokens as marker events so downstream consumers (host link, next-layer router) see per-channel AER in timestep order.

---
 rtl/conv_pkg.sv | 44 ++++
 rtl/lowest_set_bit_encoder.sv | 24 ++
 rtl/spike_event_serializer.sv | 201 ++++++++++++++++++++
 tb/tb_spike_event_serializer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and width/offset helpers for the spike event serializer and its consumers.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIKES = 2'd1,
    MARK   = 2'd2
  } serializer_state_t;

  // Pooled coordinates drop one bit relative to the producer coordinate.
  function automatic int unsigned coord_w(input int unsigned bits_per_coordinate);
    return bits_per_coordinate - 1;
  endfunction

  function automatic int unsigned chan_w(input int unsigned out_channels);
    return (out_channels <= 2) ? 1 : $clog2(out_channels);
  endfunction

  function automatic int unsigned in_width(input int unsigned cw, input int unsigned out_channels);
    return 2 * cw + out_channels + 1;
  endfunction

  function automatic int unsigned out_width(input int unsigned cw, input int unsigned ch_w);
    return 1 + 2 * cw + ch_w;
  endfunction

  // Out-event field offsets (LSB positions), MSB->LSB: marker, x, y, ch.
  function automatic int unsigned out_ch_lsb();
    return 0;
  endfunction

  function automatic int unsigned out_y_lsb(input int unsigned ch_w);
    return ch_w;
  endfunction

  function automatic int unsigned out_x_lsb(input int unsigned cw, input int unsigned ch_w);
    return ch_w + cw;
  endfunction

  function automatic int unsigned out_marker_bit(input int unsigned cw, input int unsigned ch_w);
    return ch_w + 2 * cw;
  endfunction

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// Combinational priority encoder: index of the lowest set bit of mask, plus an any-set flag.
module lowest_set_bit_encoder
  import conv_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = chan_w(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = IDX_W'(i);
      end
    end
    any = |mask;
  end

endmodule

// File: rtl/spike_event_serializer.sv
// Buffers pooled spike vectors and serializes them into per-channel address events plus
// timestep markers. Defining SPIKE_SERIALIZER_COUNT_EN adds a per-timestep event counter port.
module spike_event_serializer
  import conv_pkg::*;
#(
  parameter  int unsigned BITS_PER_COORDINATE = 8,
  parameter  int unsigned OUT_CHANNELS        = 8,
  parameter  int unsigned FIFO_DEPTH          = 16,
  localparam int unsigned CW                  = coord_w(BITS_PER_COORDINATE),
  localparam int unsigned CH_W                = chan_w(OUT_CHANNELS),
  localparam int unsigned IN_W                = in_width(CW, OUT_CHANNELS),
  localparam int unsigned OUT_W               = out_width(CW, CH_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_write_enable,
  output logic             in_full_next,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
`ifdef SPIKE_SERIALIZER_COUNT_EN
  ,
  output logic [31:0]      event_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  // ---------------- input FIFO (show-ahead, wrap-bit pointers) ----------------
  logic [IN_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   count_c, count_d;
  logic            full_c, empty_c, push_c, pop_c;
  logic            in_full_next_q, overflow_q;

  assign count_c  = wr_ptr_q - rd_ptr_q;
  assign full_c   = (count_c == PW'(FIFO_DEPTH));
  assign empty_c  = (count_c == '0);
  assign push_c   = in_write_enable && !full_c;
  assign wr_ptr_d = wr_ptr_q + PW'(push_c);
  assign rd_ptr_d = rd_ptr_q + PW'(pop_c);
  assign count_d  = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  // Full flag leaves one slot of slack for a producer that reacts a cycle late.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      in_full_next_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      in_full_next_q <= (count_d >= PW'(FIFO_DEPTH - 1));
      overflow_q     <= overflow_q || (in_write_enable && full_c);
    end
  end

  // ---------------- head word decode ----------------
  logic [IN_W-1:0]         head_c;
  logic                    head_ts_c;
  logic [CW-1:0]           head_x_c, head_y_c;
  logic [OUT_CHANNELS-1:0] head_spikes_c;

  assign head_c        = mem_q[rd_ptr_q[AW-1:0]];
  assign head_ts_c     = head_c[IN_W-1];
  assign head_x_c      = head_c[OUT_CHANNELS+CW +: CW];
  assign head_y_c      = head_c[OUT_CHANNELS +: CW];
  assign head_spikes_c = head_c[0 +: OUT_CHANNELS];

  // ---------------- work register and serializer FSM ----------------
  serializer_state_t       state_q, state_d;
  logic [CW-1:0]           x_q, x_d, y_q, y_d;
  logic [OUT_CHANNELS-1:0] rem_q, rem_d, rem_clr_c;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_valid_q;
  logic [CH_W-1:0]         ch_q, idx_clr_c, idx_head_c;
  logic                    any_clr_c, any_head_c, accept_c, load_c;

  assign ch_q      = out_data_q[CH_W-1:0];
  assign rem_clr_c = rem_q & ~(OUT_CHANNELS'(1) << ch_q);
  assign accept_c  = out_valid_q && out_ready;

  // Remaining channels after the current beat: next ch and the last-bit test.
  lowest_set_bit_encoder #(
    .WIDTH (OUT_CHANNELS)
  ) u_enc_rem (
    .mask  (rem_clr_c),
    .index (idx_clr_c),
    .any   (any_clr_c)
  );

  lowest_set_bit_encoder #(
    .WIDTH (OUT_CHANNELS)
  ) u_enc_head (
    .mask  (head_spikes_c),
    .index (idx_head_c),
    .any   (any_head_c)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    load_c     = 1'b0;
    pop_c      = 1'b0;

    unique case (state_q)
      IDLE: load_c = 1'b1;
      SPIKES: begin
        if (accept_c) begin
          if (any_clr_c) begin
            rem_d      = rem_clr_c;
            out_data_d = {1'b0, x_q, y_q, idx_clr_c};
          end else begin
            load_c = 1'b1;
          end
        end
      end
      MARK: load_c = accept_c;
      default: state_d = IDLE;
    endcase

    // Load pops the head; an all-zero vector is dropped and leaves the block idle for a cycle.
    if (load_c) begin
      state_d    = IDLE;
      x_d        = '0;
      y_d        = '0;
      rem_d      = '0;
      out_data_d = '0;
      if (!empty_c) begin
        pop_c = 1'b1;
        if (head_ts_c) begin
          state_d    = MARK;
          out_data_d = {1'b1, {(OUT_W-1){1'b0}}};
        end else if (any_head_c) begin
          state_d    = SPIKES;
          x_d        = head_x_c;
          y_d        = head_y_c;
          rem_d      = head_spikes_c;
          out_data_d = {1'b0, head_x_c, head_y_c, idx_head_c};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= (state_d != IDLE);
    end
  end

`ifdef SPIKE_SERIALIZER_COUNT_EN
  // Per-timestep count of accepted spike events; a marker restarts it.
  logic [31:0] event_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      event_count_q <= '0;
    end else if (accept_c) begin
      if (state_q == MARK) begin
        event_count_q <= '0;
      end else if (event_count_q != '1) begin
        event_count_q <= event_count_q + 32'd1;
      end
    end
  end

  assign event_count = event_count_q;
`endif

  assign in_full_next = in_full_next_q;
  assign overflow     = overflow_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_spike_event_serializer.sv
// Randomized bench for spike_event_serializer against a queue-based event-stream model.
module tb_spike_event_serializer;

  localparam int unsigned BPC   = 8;
  localparam int unsigned OC    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = BPC - 1;
  localparam int unsigned CHW   = 3;
  localparam int unsigned IN_W  = 2 * CW + OC + 1;
  localparam int unsigned OUT_W = 1 + 2 * CW + CHW;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_write_enable = 1'b0;
  logic             in_full_next;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             overflow;
`ifdef SPIKE_SERIALIZER_COUNT_EN
  logic [31:0]      event_count;
`endif

  spike_event_serializer #(
    .BITS_PER_COORDINATE (BPC),
    .OUT_CHANNELS        (OC),
    .FIFO_DEPTH          (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_data         (in_data),
    .in_write_enable (in_write_enable),
    .in_full_next    (in_full_next),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .overflow        (overflow)
`ifdef SPIKE_SERIALIZER_COUNT_EN
    ,
    .event_count     (event_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference event stream: marker = top bit, then x, y, ch by plain arithmetic.
  logic [63:0] exp_q[$];
  bit          rdy_rand = 1'b0;

  function automatic logic [63:0] ev(input int mk, input int x, input int y, input int ch);
    longint v;
    v = longint'(mk) * (longint'(1) << (OUT_W - 1))
      + longint'(x) * (longint'(1) << (CW + CHW))
      + longint'(y) * (longint'(1) << CHW)
      + longint'(ch);
    return 64'(v);
  endfunction

  task automatic expand(input int ts, input int x, input int y, input int sp);
    if (ts != 0) begin
      exp_q.push_back(ev(1, 0, 0, 0));
    end else begin
      for (int c = 0; c < int'(OC); c++) begin
        if (((sp >> c) & 1) != 0) exp_q.push_back(ev(0, x, y, c));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic write_word(input int ts, input int x, input int y, input int sp, input bit keep);
    in_data         = {1'(ts), CW'(x), CW'(y), OC'(sp)};
    in_write_enable = 1'b1;
    if (keep) expand(ts, x, y, sp);
    tick();
    in_write_enable = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    check_val("drain_done", 64'(done), 64'(1));
  endtask

  // Monitor: accepted events in order, stall stability, per-timestep count.
  bit              prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data = '0;
  int unsigned     mcnt = 0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (reset) begin
      prev_stall = 1'b0;
      mcnt       = 0;
    end else begin
      if (prev_stall) begin
        check_val("hold_valid", 64'(out_valid), 64'(1));
        check_val("hold_data", 64'(out_data), 64'(prev_data));
      end
`ifdef SPIKE_SERIALIZER_COUNT_EN
      check_val("event_count", 64'(event_count), 64'(mcnt));
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("event_expected", 64'(exp_q.size() != 0), 64'(1));
        end else begin
          e = exp_q.pop_front();
          check_val("event", 64'(out_data), e);
          if (e[OUT_W-1]) mcnt = 0;
          else if (mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    int pat[5] = '{1, 0, 0, 1, 1};
    int run;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", 64'(out_valid), 64'(0));
    check_val("rst_data", 64'(out_data), 64'(0));
    check_val("rst_full_next", 64'(in_full_next), 64'(0));
    check_val("rst_overflow", 64'(overflow), 64'(0));
    reset = 1'b0;
    tick();

    // Basic vector and first-event latency.
    out_ready = 1'b1;
    write_word(0, 3, 5, 8'hA1, 1'b1);
    check_val("latency_n", 64'(out_valid), 64'(0));
    tick();
    check_val("latency_n1", 64'(out_valid), 64'(1));
    drain(50);

    // Stalls with ready pattern 1,0,0,1,1.
    write_word(0, 3, 5, 8'hA1, 1'b1);
    tick();
    foreach (pat[k]) begin
      out_ready = pat[k][0];
      tick();
    end
    out_ready = 1'b1;
    drain(50);

    // Vector, marker, vector queued behind a stall: no bubbles once released.
    out_ready = 1'b0;
    write_word(0, 1, 2, 8'h03, 1'b1);
    write_word(1, 0, 0, 8'hFF, 1'b1);
    write_word(0, 4, 6, 8'h80, 1'b1);
    tick();
    out_ready = 1'b1;
    run = 0;
    while (out_valid && run < 20) begin
      run++;
      tick();
    end
    check_val("no_bubble_run", 64'(run), 64'(4));
    drain(20);

    // Empty vector is dropped silently.
    write_word(0, 9, 9, 0, 1'b1);
    write_word(0, 2, 7, 8'h04, 1'b1);
    drain(50);

    // Fill: first word moves into the work register, then 16 fill the FIFO, 18th is lost.
    out_ready = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      write_word(0, $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(1, 255), k != 18);
      if (k == 15) check_val("full_next_at14", 64'(in_full_next), 64'(0));
      if (k == 16) check_val("full_next_at15", 64'(in_full_next), 64'(1));
      if (k == 17) check_val("overflow_before", 64'(overflow), 64'(0));
      if (k == 18) check_val("overflow_set", 64'(overflow), 64'(1));
    end
    out_ready = 1'b1;
    drain(300);
    check_val("overflow_sticky", 64'(overflow), 64'(1));
    check_val("full_next_drained", 64'(in_full_next), 64'(0));

    // Randomized bursts (never more than FIFO_DEPTH-1 words outstanding).
    rdy_rand = 1'b1;
    for (int b = 0; b < 25; b++) begin
      n = $urandom_range(1, 15);
      for (int w = 0; w < n; w++) begin
        write_word(($urandom_range(0, 7) == 0) ? 1 : 0,
                   $urandom_range(0, 127), $urandom_range(0, 127),
                   ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255), 1'b1);
        repeat ($urandom_range(0, 2)) tick();
      end
      drain(400);
    end
    rdy_rand  = 1'b0;
    out_ready = 1'b1;

    // Counter restart across a marker: five spikes, marker, one spike.
    out_ready = 1'b0;
    write_word(0, 1, 1, 8'h1F, 1'b1);
    write_word(1, 0, 0, 0, 1'b1);
    write_word(0, 2, 2, 8'h01, 1'b1);
    tick();
    out_ready = 1'b1;
    drain(50);
`ifdef SPIKE_SERIALIZER_COUNT_EN
    check_val("count_after_marker", 64'(event_count), 64'(1));
`endif

    // Reset in the middle of a vector discards everything.
    write_word(0, 3, 3, 8'hFF, 1'b1);
    write_word(0, 4, 4, 8'hFF, 1'b1);
    tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    check_val("midrst_valid", 64'(out_valid), 64'(0));
    check_val("midrst_data", 64'(out_data), 64'(0));
    reset = 1'b0;
    repeat (3) tick();
    check_val("postrst_idle", 64'(out_valid), 64'(0));
    check_val("postrst_overflow", 64'(overflow), 64'(0));
    check_val("postrst_full_next", 64'(in_full_next), 64'(0));
`ifdef SPIKE_SERIALIZER_COUNT_EN
    check_val("postrst_count", 64'(event_count), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
